// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// fifo_arb_pkg : shared types and round-robin pick helper for fifo_wr_arbiter
// Revision     : 1.0
// ============================================================================
package fifo_arb_pkg;

    localparam int unsigned c_MAX_REQ = 16;
    localparam int unsigned c_IDX_W   = 4;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               found;
        logic [c_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search valid starting at ptr, wrapping modulo n; ptr is assumed < n.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_REQ-1:0] valid,
        input logic [c_IDX_W-1:0]   ptr,
        input int unsigned          n
    );
        rr_pick_t   res;
        logic [5:0] sum;
        res = '0;
        for (int unsigned i = 0; i < c_MAX_REQ; i++) begin
            sum = 6'(ptr) + 6'(i);
            if (sum >= 6'(n)) begin
                sum = sum - 6'(n);
            end
            if ((i < n) && !res.found && valid[sum[c_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = sum[c_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin arbiter (one-hot grant + index)
// Revision   : 1.0
// ============================================================================
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SRC_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [SRC_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [c_MAX_REQ-1:0] w_req_ext;
    logic [c_IDX_W-1:0]   w_ptr_ext;
    rr_pick_t             w_pick;
    logic                 w_unused;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NREQ-1:0]    = req_i;
        w_ptr_ext              = '0;
        w_ptr_ext[SRC_W-1:0]   = ptr_i;
        w_pick                 = rr_pick(w_req_ext, w_ptr_ext, NREQ);
        grant_idx_o            = w_pick.idx[SRC_W-1:0];
        any_o                  = w_pick.found;
        grant_o                = '0;
        if (w_pick.found) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    assign w_unused = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : packet-locking round-robin share of one fifo write port,
//                   with a one-entry holding register and flush sequencing
// Revision        : 1.0
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter type DTYPE = logic [31:0],
    parameter int  SRC_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_last,
    input  DTYPE             req_data [NREQ],
    output logic [NREQ-1:0]  req_ready,
    output logic             fifo_rst,
    output logic             fifo_wen,
    output DTYPE             fifo_wdata,
    input  logic             fifo_full,
    output logic [SRC_W-1:0] cur_src,
    output logic             locked
);

    arb_state_e       state_q, state_d;
    logic             hold_valid_q, hold_valid_d;
    DTYPE             hold_data_q, hold_data_d;
    logic [SRC_W-1:0] cur_src_q, cur_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             fifo_rst_q;

    logic [NREQ-1:0]  w_grant;
    logic [SRC_W-1:0] w_grant_idx;
    logic             w_any;
    logic             w_hold_free;
    logic             w_accept;
    logic             w_last;
    logic [SRC_W-1:0] w_sel;
    logic [SRC_W-1:0] w_next_ptr;

    rr_arbiter #(
        .NREQ  (NREQ),
        .SRC_W (SRC_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .any_o       (w_any)
    );

    assign fifo_wen    = hold_valid_q & ~fifo_full & ~fifo_rst_q;
    assign fifo_wdata  = hold_data_q;
    assign w_hold_free = ~hold_valid_q | fifo_wen;

    // rst_n gates ready so nothing is offered while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && !flush && w_hold_free) begin
            if (state_q == LOCK) begin
                req_ready[cur_src_q] = 1'b1;
            end else if (w_any) begin
                req_ready = w_grant;
            end
        end
    end

    assign w_sel      = (state_q == LOCK) ? cur_src_q : w_grant_idx;
    assign w_accept   = |(req_valid & req_ready);
    assign w_last     = req_last[w_sel];
    assign w_next_ptr = (w_grant_idx == SRC_W'(NREQ - 1)) ? '0 : w_grant_idx + SRC_W'(1);

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        cur_src_d    = cur_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (flush) begin
            hold_valid_d = 1'b0;
            state_d      = ARB;
        end else if (w_accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = req_data[w_sel];
            if (state_q == ARB) begin
                rr_ptr_d  = w_next_ptr;
                cur_src_d = w_grant_idx;
                state_d   = w_last ? ARB : LOCK;
            end else if (w_last) begin
                state_d = ARB;
            end
        end else if (fifo_wen) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            cur_src_q    <= '0;
            rr_ptr_q     <= '0;
            fifo_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            cur_src_q    <= cur_src_d;
            rr_ptr_q     <= rr_ptr_d;
            fifo_rst_q   <= flush;
        end
    end

    assign fifo_rst = fifo_rst_q;
    assign cur_src  = cur_src_q;
    assign locked   = (state_q == LOCK);

endmodule
`default_nettype wire
